// File: rtl/multicore_system_nios2_dbg_pkg.sv
// Shared definitions for the Nios II debug virtual-JTAG link: IR codes, default scan length, FSM states.
package multicore_system_nios2_dbg_pkg;

    localparam int SR_WIDTH_DEF = 38;
    localparam int IR_WIDTH_DEF = 2;

    localparam logic [1:0] IR_OCIMEM    = 2'd0;
    localparam logic [1:0] IR_TRACEMEM  = 2'd1;
    localparam logic [1:0] IR_BREAK     = 2'd2;
    localparam logic [1:0] IR_TRACECTRL = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UIR,
        ST_CDR,
        ST_SDR,
        ST_UDR,
        ST_RTI,
        ST_RESP
    } vjtag_state_e;

endpackage

// File: rtl/multicore_system_nios2_dbg_tck_gen.sv
// TCK generator: low half then high half of TCK_DIV clks each, with one-clk strobes on the
// edge that starts the next period (fall_en) and the edge that raises TCK (pre_rise_en).
module multicore_system_nios2_dbg_tck_gen #(
    parameter int TCK_DIV = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    output logic tck,
    output logic fall_en,
    output logic pre_rise_en
);

    localparam int CW = (2 * TCK_DIV > 2) ? $clog2(2 * TCK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(2 * TCK_DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(TCK_DIV);
    localparam logic [CW-1:0] PRE  = CW'(TCK_DIV - 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    always_comb begin
        cnt_nxt = (cnt == LAST) ? '0 : cnt + 1'b1;
    end

    // Disabled generator parks in the low phase so the first enabled clk starts a fresh period
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
            tck <= 1'b0;
        end else if (!en) begin
            cnt <= '0;
            tck <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            tck <= (cnt_nxt >= HALF);
        end
    end

    assign fall_en     = en && (cnt == LAST);
    assign pre_rise_en = en && (cnt == PRE);

endmodule

// File: rtl/multicore_system_nios2_debug_vjtag_master.sv
// Virtual-JTAG initiator: turns one (IR, data) command into a UIR/CDR/SDR/UDR/RTI scan toward the
// Nios II debug slave and returns the TDO bits shifted out during SDR.
module multicore_system_nios2_debug_vjtag_master
    import multicore_system_nios2_dbg_pkg::*;
#(
    parameter int SR_WIDTH = SR_WIDTH_DEF,
    parameter int IR_WIDTH = IR_WIDTH_DEF,
    parameter int TCK_DIV  = 2,
    parameter int RTI_TCKS = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [SR_WIDTH-1:0] cmd_data,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [SR_WIDTH-1:0] rsp_data,
    output logic [IR_WIDTH-1:0] rsp_ir_out,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [IR_WIDTH-1:0] vji_ir_in,
    input  logic [IR_WIDTH-1:0] vji_ir_out,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                vji_rti
);

    localparam int MAX_CNT = (SR_WIDTH > RTI_TCKS) ? SR_WIDTH : RTI_TCKS;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam logic [CNT_W-1:0] SR_LAST  = CNT_W'(SR_WIDTH - 1);
    localparam logic [CNT_W-1:0] RTI_LAST = CNT_W'(RTI_TCKS - 1);

    vjtag_state_e        state;
    logic [CNT_W-1:0]    per_cnt;
    logic [SR_WIDTH-1:0] shift_sr;
    logic [SR_WIDTH-1:0] cap;
    logic                tck_en;
    logic                fall_en;
    logic                pre_rise_en;
    logic                accept;

    assign tck_en   = (state != ST_IDLE) && (state != ST_RESP);
    assign accept   = (state == ST_IDLE) && cmd_valid && cmd_ready;
    assign rsp_data = cap;

    multicore_system_nios2_dbg_tck_gen #(
        .TCK_DIV (TCK_DIV)
    ) u_tck_gen (
        .clk         (clk),
        .reset_n     (reset_n),
        .en          (tck_en),
        .tck         (vji_tck),
        .fall_en     (fall_en),
        .pre_rise_en (pre_rise_en)
    );

    // Outgoing data: bit 0 always holds the next bit to present on tdi
    always_ff @(posedge clk) begin
        if (accept) begin
            shift_sr <= cmd_data;
        end else if (fall_en && ((state == ST_CDR) || (state == ST_SDR))) begin
            shift_sr <= shift_sr >> 1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            per_cnt    <= '0;
            cap        <= '0;
            cmd_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_ir_out <= '0;
            vji_tdi    <= 1'b0;
            vji_ir_in  <= '0;
            vji_uir    <= 1'b0;
            vji_cdr    <= 1'b0;
            vji_sdr    <= 1'b0;
            vji_udr    <= 1'b0;
            vji_rti    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        cmd_ready <= 1'b0;
                        vji_ir_in <= cmd_ir;
                        vji_uir   <= 1'b1;
                        state     <= ST_UIR;
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                ST_UIR: begin
                    if (fall_en) begin
                        vji_uir <= 1'b0;
                        vji_cdr <= 1'b1;
                        state   <= ST_CDR;
                    end
                end
                ST_CDR: begin
                    if (pre_rise_en) begin
                        rsp_ir_out <= vji_ir_out;
                    end
                    if (fall_en) begin
                        vji_cdr <= 1'b0;
                        vji_sdr <= 1'b1;
                        vji_tdi <= shift_sr[0];
                        per_cnt <= '0;
                        state   <= ST_SDR;
                    end
                end
                ST_SDR: begin
                    // Capture fills from the top so the first bit out lands in cap[0]
                    if (pre_rise_en) begin
                        cap <= {vji_tdo, cap[SR_WIDTH-1:1]};
                    end
                    if (fall_en) begin
                        if (per_cnt == SR_LAST) begin
                            per_cnt <= '0;
                            vji_sdr <= 1'b0;
                            vji_udr <= 1'b1;
                            vji_tdi <= 1'b0;
                            state   <= ST_UDR;
                        end else begin
                            per_cnt <= per_cnt + 1'b1;
                            vji_tdi <= shift_sr[0];
                        end
                    end
                end
                ST_UDR: begin
                    if (fall_en) begin
                        per_cnt <= '0;
                        vji_udr <= 1'b0;
                        vji_rti <= 1'b1;
                        state   <= ST_RTI;
                    end
                end
                ST_RTI: begin
                    if (fall_en) begin
                        if (per_cnt == RTI_LAST) begin
                            per_cnt   <= '0;
                            vji_rti   <= 1'b0;
                            rsp_valid <= 1'b1;
                            state     <= ST_RESP;
                        end else begin
                            per_cnt <= per_cnt + 1'b1;
                        end
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multicore_system_nios2_debug_vjtag_master.sv
// Scoreboard bench for the virtual-JTAG master with a loopback slave model on the vji_* side.
module tb_multicore_system_nios2_debug_vjtag_master;

    localparam int SRW = 38;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic           cmd_valid, cmd_ready, rsp_valid, rsp_ready;
    logic [1:0]     cmd_ir, rsp_ir_out, vji_ir_in, vji_ir_out;
    logic [SRW-1:0] cmd_data, rsp_data;
    logic           vji_tck, vji_tdi, vji_tdo, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;

    logic           cmd_valid2, cmd_ready2, rsp_valid2, rsp_ready2;
    logic [1:0]     cmd_ir2, rsp_ir_out2, vji_ir_in2;
    logic [SRW-1:0] cmd_data2, rsp_data2;
    logic           vji_tck2, vji_tdi2, vji_tdo2, vji_uir2, vji_cdr2, vji_sdr2, vji_udr2, vji_rti2;

    multicore_system_nios2_debug_vjtag_master dut (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ir(cmd_ir), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_ir_out(rsp_ir_out), .vji_tck(vji_tck), .vji_tdi(vji_tdi),
        .vji_tdo(vji_tdo), .vji_ir_in(vji_ir_in), .vji_ir_out(vji_ir_out), .vji_uir(vji_uir),
        .vji_cdr(vji_cdr), .vji_sdr(vji_sdr), .vji_udr(vji_udr), .vji_rti(vji_rti)
    );

    multicore_system_nios2_debug_vjtag_master #(.TCK_DIV(1), .RTI_TCKS(1)) dut2 (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
        .cmd_ir(cmd_ir2), .cmd_data(cmd_data2), .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2),
        .rsp_data(rsp_data2), .rsp_ir_out(rsp_ir_out2), .vji_tck(vji_tck2), .vji_tdi(vji_tdi2),
        .vji_tdo(vji_tdo2), .vji_ir_in(vji_ir_in2), .vji_ir_out(2'b00), .vji_uir(vji_uir2),
        .vji_cdr(vji_cdr2), .vji_sdr(vji_sdr2), .vji_udr(vji_udr2), .vji_rti(vji_rti2)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Loopback slaves: tdo = tdi delayed one TCK, cleared on CDR capture
    logic       tdo_q, tdo_q2;
    logic [1:0] slv_ir_out;
    assign vji_tdo    = tdo_q;
    assign vji_tdo2   = tdo_q2;
    assign vji_ir_out = slv_ir_out;
    always @(posedge vji_tck or negedge reset_n)
        if (!reset_n) tdo_q <= 1'b0;
        else if (vji_cdr) tdo_q <= 1'b0;
        else if (vji_sdr) tdo_q <= vji_tdi;
    always @(posedge vji_tck2 or negedge reset_n)
        if (!reset_n) tdo_q2 <= 1'b0;
        else if (vji_cdr2) tdo_q2 <= 1'b0;
        else if (vji_sdr2) tdo_q2 <= vji_tdi2;

    typedef struct {
        logic [SRW-1:0] data;
        logic [1:0]     ir;
        int             t0;
    } exp_t;
    exp_t exp_q[$];
    exp_t e_mon;

    logic tck_d = 1'b0, tdi_d = 1'b0, rv_d = 1'b0, uir_d = 1'b0, udr2_d = 1'b0;
    int n_uir = 0, n_cdr = 0, n_sdr = 0, n_udr = 0, n_rti = 0;
    int scans_started = 0, tdi_glitch = 0, onehot_err = 0, ta_seen2 = 0, ta_bad2 = 0;

    always @(negedge clk) begin
        if (!reset_n) begin
            tck_d <= 1'b0; tdi_d <= 1'b0; rv_d <= 1'b0; uir_d <= 1'b0;
            n_uir <= 0; n_cdr <= 0; n_sdr <= 0; n_udr <= 0; n_rti <= 0;
        end else begin
            if (vji_uir && !uir_d) begin
                scans_started <= scans_started + 1;
                n_uir <= 0; n_cdr <= 0; n_sdr <= 0; n_udr <= 0; n_rti <= 0;
            end
            if (vji_tck && !tck_d) begin
                if (vji_tdi !== tdi_d) tdi_glitch <= tdi_glitch + 1;
                n_uir <= n_uir + int'(vji_uir);
                n_cdr <= n_cdr + int'(vji_cdr);
                n_sdr <= n_sdr + int'(vji_sdr);
                n_udr <= n_udr + int'(vji_udr);
                n_rti <= n_rti + int'(vji_rti);
            end
            if ((int'(vji_uir) + int'(vji_cdr) + int'(vji_sdr) + int'(vji_udr) + int'(vji_rti)) > 1)
                onehot_err <= onehot_err + 1;
            if (rsp_valid && !rv_d) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 64'(rsp_data), 64'h0);
                    if (rsp_data === '0) begin
                        errors++;
                        $display("FAIL unexpected_rsp: got rsp_valid, expected none");
                    end
                end else begin
                    e_mon = exp_q.pop_front();
                    chk("rsp_data", 64'(rsp_data), 64'(e_mon.data));
                    chk("rsp_ir_out", 64'(rsp_ir_out), 64'(e_mon.ir));
                    chk("rsp_latency", 64'(cyc - e_mon.t0), 64'd181);
                    chk("tck_uir", 64'(n_uir), 64'd1);
                    chk("tck_cdr", 64'(n_cdr), 64'd1);
                    chk("tck_sdr", 64'(n_sdr), 64'd38);
                    chk("tck_udr", 64'(n_udr), 64'd1);
                    chk("tck_rti", 64'(n_rti), 64'd4);
                end
            end
            tck_d <= vji_tck;
            tdi_d <= vji_tdi;
            rv_d  <= rsp_valid;
            uir_d <= vji_uir;
        end
        udr2_d <= vji_udr2;
        if (udr2_d && !vji_udr2) begin
            ta_seen2 <= ta_seen2 + 1;
            if (!vji_rti2) ta_bad2 <= ta_bad2 + 1;
        end
    end

    task automatic send(input logic [1:0] ir, input logic [SRW-1:0] data, input logic [1:0] irout,
                        input logic [SRW-1:0] exp_data, input logic hold);
        exp_t e;
        int n;
        slv_ir_out = irout;
        cmd_ir     = ir;
        cmd_data   = data;
        @(negedge clk);
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            chk("cmd_ready_timeout", 64'(cmd_ready), 64'd1);
        end else begin
            e.data = exp_data;
            e.ir   = irout;
            e.t0   = cyc;
            exp_q.push_back(e);
        end
        @(negedge clk);
        cmd_data = ~data;
        cmd_ir   = ~ir;
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic finish_rsp(input int hold);
        int n;
        int stable_err;
        logic [SRW-1:0] snap;
        n = 0;
        while (!rsp_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) chk("rsp_timeout", 64'(rsp_valid), 64'd1);
        cmd_valid  = 1'b0;
        snap       = rsp_data;
        stable_err = 0;
        repeat (hold) begin
            @(negedge clk);
            if (rsp_data !== snap || !rsp_valid || vji_tck || vji_uir || cmd_ready) stable_err++;
        end
        if (hold > 0) chk("rsp_hold_stable", 64'(stable_err), 64'd0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_valid_drop", 64'(rsp_valid), 64'd0);
        chk("cmd_ready_after", 64'(cmd_ready), 64'd1);
    endtask

    function automatic logic [63:0] outs1();
        return 64'({cmd_ready, rsp_valid, rsp_data, rsp_ir_out, vji_tck, vji_tdi, vji_ir_in,
                    vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti});
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int t0;
        cmd_valid = 0; rsp_ready = 0; cmd_ir = 0; cmd_data = '0; slv_ir_out = 0;
        cmd_valid2 = 0; rsp_ready2 = 0; cmd_ir2 = 0; cmd_data2 = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", outs1(), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("cmd_ready_after_reset", 64'(cmd_ready), 64'd1);

        send(2'd2, 38'h2A_AAAA_AAAA, 2'b01, 38'h15_5555_5554, 1'b0);
        finish_rsp(0);
        send(2'd3, 38'h00_0000_0001, 2'b11, 38'h00_0000_0002, 1'b1);
        finish_rsp(0);
        chk("one_scan_per_cmd", 64'(scans_started), 64'd2);
        send(2'd0, 38'h3F_FFFF_FFFF, 2'b10, 38'h3F_FFFF_FFFE, 1'b0);
        finish_rsp(20);
        send(2'd1, 38'h12_3456_789A, 2'b00, 38'h24_68AC_F134, 1'b0);
        finish_rsp(0);

        // Reset in the middle of SDR: the in-flight scan must vanish
        send(2'd2, 38'h15_5555_5555, 2'b01, 38'h0, 1'b0);
        n = 0;
        while (n_sdr < 17 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("reached_sdr17", 64'(n_sdr >= 17), 64'd1);
        reset_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("midscan_reset_outputs", outs1(), 64'd0);
        reset_n = 1'b1;
        repeat (250) @(negedge clk);
        chk("no_rsp_after_abort", 64'(rsp_valid), 64'd0);
        send(2'd1, 38'h00_FFFF_0000, 2'b01, 38'h01_FFFE_0000, 1'b0);
        finish_rsp(0);

        // Fast TCK, single RTI period
        cmd_ir2   = 2'd2;
        cmd_data2 = 38'h2A_AAAA_AAAA;
        @(negedge clk);
        chk("dut2_cmd_ready", 64'(cmd_ready2), 64'd1);
        cmd_valid2 = 1'b1;
        t0 = cyc;
        @(negedge clk);
        cmd_valid2 = 1'b0;
        n = 0;
        while (!rsp_valid2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("dut2_latency", 64'(cyc - t0), 64'd85);
        chk("dut2_rsp_data", 64'(rsp_data2), 64'(38'h15_5555_5554));
        chk("dut2_take_action", 64'(ta_seen2), 64'd1);
        chk("dut2_take_action_in_rti", 64'(ta_bad2), 64'd0);
        rsp_ready2 = 1'b1;
        @(negedge clk);
        rsp_ready2 = 1'b0;
        chk("dut2_rsp_drop", 64'(rsp_valid2), 64'd0);

        repeat (5) @(negedge clk);
        chk("tdi_stable_at_rise", 64'(tdi_glitch), 64'd0);
        chk("flags_one_hot", 64'(onehot_err), 64'd0);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
